uart_rx_fsm: RTL and testbench

- Frame-level sequencer for the UART receiver datapath.
- Detects the start bit and runs the oversampling edge counter and bit counter.
- Issues one-cycle enable strobes to the start, parity and stop checkers and to the deserializer, then gathers their registered error flags.
- Raises DATA_VALID for each clean frame. Sits between RX_IN and the RX sampler, checkers and deserializer, in the UART clock domain.

---
 rtl/uart_rx_fsm.sv | 146 ++++++++++++++
 tb/tb_uart_rx_fsm.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer: start detection, oversample edge and bit
// counting, checker/deserializer strobes and DATA_VALID for clean frames.
module uart_rx_fsm #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          RX_IN,
    input  logic                          PAR_EN,
    input  logic [PRESCALE_W-1:0]         PRESCALE,
    input  logic                          STRT_GLITCH,
    input  logic                          PAR_ERR,
    input  logic                          STP_ERR,
    output logic [PRESCALE_W-1:0]         EDGE_CNT,
    output logic [$clog2(DATA_WIDTH)-1:0] BIT_CNT,
    output logic                          DAT_SAMP_EN,
    output logic                          STRT_CHK_EN,
    output logic                          DESER_EN,
    output logic                          PAR_CHK_EN,
    output logic                          STP_CHK_EN,
    output logic                          DATA_VALID
);

    localparam int unsigned      BIT_W    = $clog2(DATA_WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  par_en_q;
    logic                  par_err_q;

    logic [PRESCALE_W-1:0] mid;
    logic [PRESCALE_W-1:0] last;
    logic [PRESCALE_W-1:0] edge_nxt;
    logic                  at_last;
    logic                  at_mid_nxt;

    // Bit timing from the prescale captured at start detection
    always_comb begin
        mid        = (prescale_q >> 1) + PRESCALE_W'(2);
        last       = prescale_q - PRESCALE_W'(1);
        at_last    = (EDGE_CNT == last);
        edge_nxt   = at_last ? '0 : EDGE_CNT + PRESCALE_W'(1);
        at_mid_nxt = (edge_nxt == mid);
    end

    // Strobes are registered one cycle ahead so they line up with EDGE_CNT==MID
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            prescale_q  <= '0;
            par_en_q    <= 1'b0;
            par_err_q   <= 1'b0;
            EDGE_CNT    <= '0;
            BIT_CNT     <= '0;
            DAT_SAMP_EN <= 1'b0;
            STRT_CHK_EN <= 1'b0;
            DESER_EN    <= 1'b0;
            PAR_CHK_EN  <= 1'b0;
            STP_CHK_EN  <= 1'b0;
            DATA_VALID  <= 1'b0;
        end else begin
            STRT_CHK_EN <= 1'b0;
            DESER_EN    <= 1'b0;
            PAR_CHK_EN  <= 1'b0;
            STP_CHK_EN  <= 1'b0;
            DATA_VALID  <= 1'b0;
            case (state)
                S_IDLE: begin
                    EDGE_CNT    <= '0;
                    BIT_CNT     <= '0;
                    DAT_SAMP_EN <= 1'b0;
                    par_err_q   <= 1'b0;
                    if (!RX_IN) begin
                        state       <= S_START;
                        EDGE_CNT    <= PRESCALE_W'(1);
                        DAT_SAMP_EN <= 1'b1;
                        prescale_q  <= PRESCALE;
                        par_en_q    <= PAR_EN;
                    end
                end
                S_START: begin
                    EDGE_CNT    <= edge_nxt;
                    STRT_CHK_EN <= at_mid_nxt;
                    if (at_last) begin
                        if (STRT_GLITCH) begin
                            state       <= S_IDLE;
                            DAT_SAMP_EN <= 1'b0;
                        end else begin
                            state   <= S_DATA;
                            BIT_CNT <= '0;
                        end
                    end
                end
                S_DATA: begin
                    EDGE_CNT <= edge_nxt;
                    DESER_EN <= at_mid_nxt;
                    if (at_last) begin
                        if (BIT_CNT != BIT_LAST) begin
                            BIT_CNT <= BIT_CNT + BIT_W'(1);
                        end else if (par_en_q) begin
                            state <= S_PARITY;
                        end else begin
                            state <= S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    EDGE_CNT   <= edge_nxt;
                    PAR_CHK_EN <= at_mid_nxt;
                    if (at_last) begin
                        par_err_q <= PAR_ERR;
                        state     <= S_STOP;
                    end
                end
                S_STOP: begin
                    EDGE_CNT   <= edge_nxt;
                    STP_CHK_EN <= at_mid_nxt;
                    if (at_last) begin
                        state       <= S_IDLE;
                        DAT_SAMP_EN <= 1'b0;
                        BIT_CNT     <= '0;
                        par_err_q   <= 1'b0;
                        DATA_VALID  <= !STP_ERR && !par_err_q;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    EDGE_CNT    <= '0;
                    BIT_CNT     <= '0;
                    DAT_SAMP_EN <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: a frame-position reference model compared every cycle,
// plus directed timing checks with hand-computed expectations.
module tb_uart_rx_fsm;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK         = 1'b0;
    logic          RST         = 1'b0;
    logic          RX_IN       = 1'b1;
    logic          PAR_EN      = 1'b0;
    logic [PW-1:0] PRESCALE    = 6'd8;
    logic          STRT_GLITCH = 1'b0;
    logic          PAR_ERR     = 1'b0;
    logic          STP_ERR     = 1'b0;
    logic [PW-1:0] EDGE_CNT;
    logic [2:0]    BIT_CNT;
    logic          DAT_SAMP_EN;
    logic          STRT_CHK_EN;
    logic          DESER_EN;
    logic          PAR_CHK_EN;
    logic          STP_CHK_EN;
    logic          DATA_VALID;

    uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PAR_EN     (PAR_EN),
        .PRESCALE   (PRESCALE),
        .STRT_GLITCH(STRT_GLITCH),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR),
        .EDGE_CNT   (EDGE_CNT),
        .BIT_CNT    (BIT_CNT),
        .DAT_SAMP_EN(DAT_SAMP_EN),
        .STRT_CHK_EN(STRT_CHK_EN),
        .DESER_EN   (DESER_EN),
        .PAR_CHK_EN (PAR_CHK_EN),
        .STP_CHK_EN (STP_CHK_EN),
        .DATA_VALID (DATA_VALID)
    );

    always #5 CLK = ~CLK;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;
    int t_start  = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference model: frame position in oversample cycles since start edge 0
    bit m_active = 1'b0;
    int m_pos    = 0;
    int m_p      = 8;
    bit m_pe     = 1'b0;
    bit m_perr   = 1'b0;
    bit m_dv     = 1'b0;

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_active <= 1'b0;
            m_pos    <= 0;
            m_perr   <= 1'b0;
            m_dv     <= 1'b0;
        end else begin
            m_dv <= 1'b0;
            if (!m_active) begin
                if (!RX_IN) begin
                    m_active <= 1'b1;
                    m_pos    <= 1;
                    m_p      <= int'(PRESCALE);
                    m_pe     <= PAR_EN;
                    m_perr   <= 1'b0;
                end
            end else begin
                m_pos <= m_pos + 1;
                if (m_pos % m_p == m_p - 1) begin
                    if (m_pos / m_p == 0 && STRT_GLITCH) m_active <= 1'b0;
                    else if (m_pe && m_pos / m_p == DW + 1) m_perr <= PAR_ERR;
                    else if (m_pos / m_p == DW + 1 + int'(m_pe)) begin
                        m_active <= 1'b0;
                        m_dv     <= !STP_ERR && !m_perr;
                    end
                end
            end
        end
    end

    function automatic void calc_exp(output int xe, output int xb, output bit xs,
                                     output bit xst, output bit xd, output bit xp,
                                     output bit xsp);
        int b, e, nb, mid;
        xe = 0; xb = 0; xs = 1'b0; xst = 1'b0; xd = 1'b0; xp = 1'b0; xsp = 1'b0;
        if (m_active) begin
            b   = m_pos / m_p;
            e   = m_pos % m_p;
            nb  = DW + 2 + int'(m_pe);
            mid = m_p / 2 + 2;
            xe  = e;
            xs  = 1'b1;
            xb  = (b == 0) ? 0 : ((b <= DW) ? b - 1 : DW - 1);
            xst = (e == mid) && (b == 0);
            xd  = (e == mid) && (b >= 1) && (b <= DW);
            xp  = (e == mid) && m_pe && (b == DW + 1);
            xsp = (e == mid) && (b == nb - 1);
        end
    endfunction

    int x_edge, x_bit;
    bit x_samp, x_strt, x_deser, x_par, x_stp;

    always @(negedge CLK) begin
        if (chk_en) begin
            calc_exp(x_edge, x_bit, x_samp, x_strt, x_deser, x_par, x_stp);
            chk("EDGE_CNT", int'(EDGE_CNT), x_edge);
            chk("BIT_CNT", int'(BIT_CNT), x_bit);
            chk("DAT_SAMP_EN", int'(DAT_SAMP_EN), int'(x_samp));
            chk("STRT_CHK_EN", int'(STRT_CHK_EN), int'(x_strt));
            chk("DESER_EN", int'(DESER_EN), int'(x_deser));
            chk("PAR_CHK_EN", int'(PAR_CHK_EN), int'(x_par));
            chk("STP_CHK_EN", int'(STP_CHK_EN), int'(x_stp));
            chk("DATA_VALID", int'(DATA_VALID), int'(m_dv));
        end
    end

    // Event log for directed timing checks
    typedef struct {
        int cyc;
        int ecnt;
        int bitc;
    } ev_t;

    ev_t strt_q[$], deser_q[$], par_q[$], stp_q[$];
    int  dv_q[$];
    int  after_dv_q[$];
    bit  dv_prev = 1'b0;

    function automatic ev_t mk_ev(input int c, input int e, input int b);
        ev_t ev;
        ev.cyc  = c;
        ev.ecnt = e;
        ev.bitc = b;
        return ev;
    endfunction

    always @(negedge CLK) begin
        if (dv_prev) after_dv_q.push_back(int'(EDGE_CNT));
        dv_prev <= DATA_VALID;
        if (STRT_CHK_EN) strt_q.push_back(mk_ev(cyc, int'(EDGE_CNT), int'(BIT_CNT)));
        if (DESER_EN)    deser_q.push_back(mk_ev(cyc, int'(EDGE_CNT), int'(BIT_CNT)));
        if (PAR_CHK_EN)  par_q.push_back(mk_ev(cyc, int'(EDGE_CNT), int'(BIT_CNT)));
        if (STP_CHK_EN)  stp_q.push_back(mk_ev(cyc, int'(EDGE_CNT), int'(BIT_CNT)));
        if (DATA_VALID)  dv_q.push_back(cyc);
    end

    task automatic clear_log();
        strt_q.delete(); deser_q.delete(); par_q.delete(); stp_q.delete();
        dv_q.delete(); after_dv_q.delete();
    endtask

    function automatic logic [PW-1:0] pick_p();
        case ($urandom_range(0, 2))
            0:       return 6'd8;
            1:       return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            RX_IN       = 1'b1;
            STRT_GLITCH = 1'($urandom_range(0, 1));
            PAR_ERR     = 1'($urandom_range(0, 1));
            STP_ERR     = 1'($urandom_range(0, 1));
        end
    endtask

    // Drive one frame; checker flags carry the planned verdict only between MID+1 and LAST
    task automatic send_frame(input int p, input bit pe, input logic [7:0] d, input bit glitch,
                              input bit perr, input bit serr, input bit rnd_cfg, input int abort_k);
        bit ln[DW+3];
        int nb, mid;
        nb  = glitch ? 1 : DW + 2 + int'(pe);
        mid = p / 2 + 2;
        ln[0] = 1'b0;
        for (int i = 0; i < DW; i++) ln[i+1] = d[i];
        if (pe) begin
            ln[DW+1] = (^d) ^ perr;
            ln[DW+2] = !serr;
        end else begin
            ln[DW+1] = !serr;
            ln[DW+2] = 1'b1;
        end
        for (int k = 0; k < p * nb; k++) begin
            int b, e;
            @(negedge CLK);
            b = k / p;
            e = k % p;
            if (k == 0) begin
                t_start  = cyc;
                PRESCALE = PW'(p);
                PAR_EN   = pe;
            end else if (rnd_cfg) begin
                PRESCALE = pick_p();
                PAR_EN   = 1'($urandom_range(0, 1));
            end
            RX_IN       = glitch ? (k >= 3) : ln[b];
            STRT_GLITCH = (b == 0 && e > mid) ? glitch : 1'($urandom_range(0, 1));
            PAR_ERR     = (pe && b == DW + 1 && e > mid) ? perr : 1'($urandom_range(0, 1));
            STP_ERR     = (!glitch && b == nb - 1 && e > mid) ? serr : 1'($urandom_range(0, 1));
            if (k == abort_k) begin
                #1;
                chk("abort_bit_cnt_before", int'(BIT_CNT), abort_k / p - 1);
                #1 RST = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0, t1, exp_dv;
        int p;
        bit pe, g, pr, sr;

        repeat (3) @(negedge CLK);
        chk_en = 1'b1;
        #1;
        chk("rst_EDGE_CNT", int'(EDGE_CNT), 0);
        chk("rst_DAT_SAMP_EN", int'(DAT_SAMP_EN), 0);
        chk("rst_DESER_EN", int'(DESER_EN), 0);
        chk("rst_DATA_VALID", int'(DATA_VALID), 0);
        @(negedge CLK);
        #2 RST = 1'b1;
        idle(3);

        // Prescale 8, no parity, 0xA5
        clear_log();
        send_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        t0 = t_start;
        idle(4);
        #1;
        chk("f1_dv_count", dv_q.size(), 1);
        if (dv_q.size() > 0) chk("f1_dv_latency", dv_q[0] - t0, 80);
        chk("f1_deser_count", deser_q.size(), 8);
        foreach (deser_q[i]) begin
            chk("f1_deser_edge", deser_q[i].ecnt, 6);
            chk("f1_deser_bit", deser_q[i].bitc, i);
        end
        chk("f1_par_count", par_q.size(), 0);
        chk("f1_strt_count", strt_q.size(), 1);

        // Prescale 16 with correct parity
        clear_log();
        send_frame(16, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        t0 = t_start;
        idle(4);
        #1;
        chk("f2_par_count", par_q.size(), 1);
        if (par_q.size() > 0) begin
            chk("f2_par_edge", par_q[0].ecnt, 10);
            chk("f2_par_bitpos", (par_q[0].cyc - t0) / 16, 9);
        end
        chk("f2_stp_count", stp_q.size(), 1);
        if (stp_q.size() > 0) begin
            chk("f2_stp_edge", stp_q[0].ecnt, 10);
            chk("f2_stp_bitpos", (stp_q[0].cyc - t0) / 16, 10);
        end
        chk("f2_dv_count", dv_q.size(), 1);
        if (dv_q.size() > 0) chk("f2_dv_latency", dv_q[0] - t0, 176);

        // Start glitch, then a genuine frame
        clear_log();
        send_frame(8, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        @(negedge CLK);
        #1;
        chk("glitch_idle_samp", int'(DAT_SAMP_EN), 0);
        chk("glitch_idle_edge", int'(EDGE_CNT), 0);
        idle(3);
        #1;
        chk("glitch_strt_count", strt_q.size(), 1);
        chk("glitch_deser_count", deser_q.size(), 0);
        chk("glitch_dv_count", dv_q.size(), 0);
        clear_log();
        send_frame(8, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        t0 = t_start;
        idle(4);
        #1;
        chk("post_glitch_dv_count", dv_q.size(), 1);
        if (dv_q.size() > 0) chk("post_glitch_dv_latency", dv_q[0] - t0, 80);

        // Parity error, stop error, then a clean frame
        clear_log();
        send_frame(16, 1'b1, 8'hF0, 1'b0, 1'b1, 1'b0, 1'b0, -1);
        idle(3);
        #1;
        chk("perr_dv_count", dv_q.size(), 0);
        chk("perr_par_count", par_q.size(), 1);
        chk("perr_stp_count", stp_q.size(), 1);
        clear_log();
        send_frame(8, 1'b0, 8'h81, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        idle(3);
        #1;
        chk("serr_dv_count", dv_q.size(), 0);
        chk("serr_stp_count", stp_q.size(), 1);
        clear_log();
        send_frame(8, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        t0 = t_start;
        idle(4);
        #1;
        chk("post_err_dv_count", dv_q.size(), 1);
        if (dv_q.size() > 0) chk("post_err_dv_latency", dv_q[0] - t0, 88);

        // Back-to-back frames at prescale 32
        clear_log();
        send_frame(32, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        t1 = t_start;
        send_frame(32, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(4);
        #1;
        chk("b2b_dv_count", dv_q.size(), 2);
        if (dv_q.size() > 1) begin
            chk("b2b_dv0_latency", dv_q[0] - t1, 320);
            chk("b2b_dv_spacing", dv_q[1] - dv_q[0], 320);
        end
        if (after_dv_q.size() > 0) chk("b2b_edge_after_dv", after_dv_q[0], 1);

        // Reset in the middle of DATA (bit 3)
        clear_log();
        send_frame(8, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 34);
        @(negedge CLK);
        #1;
        chk("abort_edge", int'(EDGE_CNT), 0);
        chk("abort_bit", int'(BIT_CNT), 0);
        chk("abort_samp", int'(DAT_SAMP_EN), 0);
        chk("abort_deser", int'(DESER_EN), 0);
        idle(2);
        @(negedge CLK);
        #2 RST = 1'b1;
        idle(2);
        #1;
        chk("abort_dv_count", dv_q.size(), 0);
        clear_log();
        send_frame(8, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        t0 = t_start;
        idle(4);
        #1;
        chk("post_abort_dv_count", dv_q.size(), 1);
        if (dv_q.size() > 0) chk("post_abort_dv_latency", dv_q[0] - t0, 80);

        // Randomized frames with mid-frame config churn
        clear_log();
        exp_dv = 0;
        for (int f = 0; f < 30; f++) begin
            p  = int'(pick_p());
            pe = 1'($urandom_range(0, 1));
            g  = ($urandom_range(0, 7) == 0);
            pr = !g && pe && ($urandom_range(0, 3) == 0);
            sr = !g && ($urandom_range(0, 4) == 0);
            if (!g && !pr && !sr) exp_dv++;
            send_frame(p, pe, 8'($urandom), g, pr, sr, 1'b1, -1);
            idle($urandom_range(0, 3));
        end
        idle(4);
        #1;
        chk("rand_dv_count", dv_q.size(), exp_dv);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
